// File: rtl/i2c_pkg.sv
// Constants shared by the I2C transmit and receive FIFOs.
package i2c_pkg;
    localparam int I2C_DATA_WIDTH    = 8;
    localparam int I2C_TX_FIFO_DEPTH = 4;
endpackage

// File: rtl/i2c_rise_detect.sv
// Turns a level into a one-cycle pulse on its low-to-high transition.
module i2c_rise_detect (
    input  logic pclk_i,
    input  logic preset_i,
    input  logic level_i,
    output logic pulse_o
);
    logic level_q;

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;
endmodule

// File: rtl/i2c_tx_fifo.sv
// Transmit byte FIFO between the register block and the I2C core, with
// sticky overflow/underflow flags and a registered pop data output.
module i2c_tx_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH,
    parameter int DEPTH      = I2C_TX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  flush_i,
    input  logic                  write_enable_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic                  read_enable_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_reg;
    logic [ADDR_WIDTH-1:0] rptr_reg;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [DATA_WIDTH-1:0] read_data_reg;
    logic                  overflow_reg;
    logic                  underflow_reg;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;

    // A held write level must push only once.
    i2c_rise_detect u_push_edge (
        .pclk_i   (pclk_i),
        .preset_i (preset_i),
        .level_i  (write_enable_i),
        .pulse_o  (push_req)
    );

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    always_comb begin
        pop_ok  = read_enable_i & (count_reg != '0);
        push_ok = push_req & ((count_reg != DEPTH_CNT) | pop_ok);
    end

    always_ff @(posedge pclk_i) begin
        if (push_ok && !flush_i) begin
            mem[wptr_reg] <= write_data_i;
        end
    end

    always_ff @(posedge pclk_i or posedge preset_i) begin
        if (preset_i) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            read_data_reg <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush_i) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rptr_reg      <= rptr_reg + ADDR_WIDTH'(1);
                read_data_reg <= mem[rptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (ADDR_WIDTH+1)'(1);
                2'b01:   count_reg <= count_reg - (ADDR_WIDTH+1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_req && !push_ok) begin
                overflow_reg <= 1'b1;
            end
            if (read_enable_i && !pop_ok) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign read_data_o = read_data_reg;
    assign count_o     = count_reg;
    assign full_o      = (count_reg == DEPTH_CNT);
    assign empty_o     = (count_reg == '0);
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;
endmodule
